// File: rtl/cache_pkg.sv
// Shared cache definitions: fill FSM states, default geometry, block-base helper.
// Reused by the I/D-cache fill controllers and tag arrays.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_ADDR_W      = 16;
  localparam int unsigned DEF_BLOCK_WORDS = 8;

  // Widest address the helper handles; callers cast in and out.
  localparam int unsigned MAX_ADDR_W = 32;

  // Byte address of the start of the block: clears bits [off_w:0].
  function automatic logic [MAX_ADDR_W-1:0] block_base(
    input logic [MAX_ADDR_W-1:0] addr,
    input int unsigned           off_w
  );
    return addr & ({MAX_ADDR_W{1'b1}} << (off_w + 1));
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-2^W counter with a latched start offset.
// o_cnt is the raw count since the last clear; o_pos is start + count (wraps).
module wrap_counter #(
  parameter int unsigned W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic [W-1:0] i_start,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_pos
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_start;

  // Count register: clear reloads the start offset, increment wraps naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_start <= '0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_start <= i_start;
    end else if (i_inc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_pos = r_start + r_cnt;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: stalls the core, streams one block from a
// pipelined memory, writes each returned word, then commits the tag.
// Optional macro CRIT_WORD_FIRST_EN: fetch starting at the missing word
// (wrapping) and add the crit_done output.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter  int unsigned DATA_W      = DEF_DATA_W,
  parameter  int unsigned ADDR_W      = DEF_ADDR_W,
  parameter  int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
  localparam int unsigned OFF_W       = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              cache_we,
  output logic [OFF_W-1:0]  cache_word_idx,
  output logic [DATA_W-1:0] cache_data,
  output logic              tag_we,
  output logic              stall
`ifdef CRIT_WORD_FIRST_EN
  ,
  output logic              crit_done
`endif
);

  localparam logic [OFF_W-1:0] LAST = OFF_W'(BLOCK_WORDS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_base;
  logic [OFF_W-1:0]  w_start;
  logic [OFF_W-1:0]  w_req_cnt;
  logic [OFF_W-1:0]  w_req_pos;
  logic [OFF_W-1:0]  w_rsp_cnt;
  logic [OFF_W-1:0]  w_rsp_pos;
  logic              w_clr;
  logic              w_req_inc;
  logic              w_rsp_acc;

`ifdef CRIT_WORD_FIRST_EN
  assign w_start = miss_addr[OFF_W:1];
`else
  assign w_start = '0;
`endif

  wrap_counter #(.W(OFF_W)) u_req_cnt (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (w_clr),
    .i_start (w_start),
    .i_inc   (w_req_inc),
    .o_cnt   (w_req_cnt),
    .o_pos   (w_req_pos)
  );

  wrap_counter #(.W(OFF_W)) u_rsp_cnt (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (w_clr),
    .i_start (w_start),
    .i_inc   (w_rsp_acc),
    .o_cnt   (w_rsp_cnt),
    .o_pos   (w_rsp_pos)
  );

  // State and block base registers; base is captured on the accepted miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_base  <= '0;
    end else begin
      r_state <= w_next;
      if (w_clr) r_base <= ADDR_W'(block_base(MAX_ADDR_W'(miss_addr), OFF_W));
    end
  end

  // Next state and all outputs; responses are accepted in FILL and DRAIN.
  always_comb begin
    w_next         = r_state;
    w_clr          = 1'b0;
    w_req_inc      = 1'b0;
    w_rsp_acc      = mem_data_valid && (r_state != IDLE);
    mem_en         = 1'b0;
    mem_addr       = '0;
    cache_we       = 1'b0;
    cache_word_idx = '0;
    cache_data     = '0;
    tag_we         = 1'b0;
    stall          = 1'b0;
`ifdef CRIT_WORD_FIRST_EN
    crit_done      = w_rsp_acc && (w_rsp_cnt == '0);
`endif

    if (w_rsp_acc) begin
      cache_we       = 1'b1;
      cache_word_idx = w_rsp_pos;
      cache_data     = mem_data_in;
    end

    case (r_state)
      IDLE: begin
        stall = miss_detected;
        if (miss_detected) begin
          w_clr  = 1'b1;
          w_next = FILL;
        end
      end
      FILL: begin
        stall     = 1'b1;
        mem_en    = 1'b1;
        mem_addr  = r_base + ADDR_W'({w_req_pos, 1'b0});
        w_req_inc = 1'b1;
        // Zero-latency memory can return the last word in the last FILL cycle.
        if (w_rsp_acc && (w_rsp_cnt == LAST)) begin
          tag_we = 1'b1;
          w_next = IDLE;
        end else if (w_req_cnt == LAST) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        stall = 1'b1;
        if (w_rsp_acc && (w_rsp_cnt == LAST)) begin
          tag_we = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
